// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array: FSM state encoding, default
// geometry constants and a helper for select-field widths.
package systolic_pkg;

  localparam int unsigned DefBitsAb = 8;
  localparam int unsigned DefBitsC  = 16;
  localparam int unsigned DefDim    = 8;

  typedef enum logic [1:0] {
    StIdle,
    StCompute,
    StFlush,
    StDone
  } state_e;

  // Width of a row-select field; never zero so DIM=1 still elaborates.
  function automatic int unsigned row_bits(input int unsigned dim);
    return (dim > 1) ? $clog2(dim) : 1;
  endfunction

endpackage

// File: rtl/systolic_array_if.sv
// Control and data bundle of the systolic array.
//   en     global enable (0 freezes everything)
//   start  begin a compute pass (honoured in idle only)
//   WrEn   load Cin into accumulator row Crow (honoured in idle only)
//   Crow   row select for write and combinational read
//   A, B   one signed operand per array row / column
//   Cin    accumulator row write data
//   Cout   accumulators of row Crow
//   busy   high whenever the sequencer is not idle
//   done   one-cycle pass-complete pulse
interface systolic_array_if
  import systolic_pkg::*;
#(
  parameter int unsigned BITS_AB = DefBitsAb,
  parameter int unsigned BITS_C  = DefBitsC,
  parameter int unsigned DIM     = DefDim
) ();

  localparam int unsigned RowW = row_bits(DIM);

  logic                              en;
  logic                              start;
  logic                              WrEn;
  logic [RowW-1:0]                   Crow;
  logic signed [DIM-1:0][BITS_AB-1:0] A;
  logic signed [DIM-1:0][BITS_AB-1:0] B;
  logic signed [DIM-1:0][BITS_C-1:0]  Cin;
  logic signed [DIM-1:0][BITS_C-1:0]  Cout;
  logic                              busy;
  logic                              done;

  modport master (
    output en, start, WrEn, Crow, A, B, Cin,
    input  Cout, busy, done
  );

  modport slave (
    input  en, start, WrEn, Crow, A, B, Cin,
    output Cout, busy, done
  );

endinterface

// File: rtl/systolic_pe.sv
// One multiply-accumulate cell of the systolic array.
//   clk, rst_n    clock, asynchronous active-low reset
//   en            enable; 0 holds every register
//   load          overwrite the accumulator with cin instead of accumulating
//   cin           accumulator load value
//   a_in, b_in    operands from the west / north neighbour
//   a_out, b_out  registered operands to the east / south neighbour
//   c             accumulator value
module systolic_pe #(
  parameter int unsigned BITS_AB = 8,
  parameter int unsigned BITS_C  = 16,
  parameter bit          SAT     = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      load,
  input  logic signed [BITS_C-1:0]  cin,
  input  logic signed [BITS_AB-1:0] a_in,
  input  logic signed [BITS_AB-1:0] b_in,
  output logic signed [BITS_AB-1:0] a_out,
  output logic signed [BITS_AB-1:0] b_out,
  output logic signed [BITS_C-1:0]  c
);

  localparam int unsigned ProdW = 2 * BITS_AB;
  localparam int unsigned ExtW  = BITS_C + 1 - ProdW;

  logic signed [BITS_AB-1:0] a_q, b_q;
  logic signed [BITS_C-1:0]  c_q, c_d;
  logic signed [ProdW-1:0]   prod;
  logic        [BITS_C:0]    sum;

  assign prod = a_in * b_in;
  // One guard bit so overflow shows up as sum[BITS_C] != sum[BITS_C-1].
  assign sum  = {c_q[BITS_C-1], c_q} + {{ExtW{prod[ProdW-1]}}, prod};

  always_comb begin
    c_d = c_q;
    if (load) begin
      c_d = cin;
    end else if (SAT && (sum[BITS_C] != sum[BITS_C-1])) begin
      c_d = sum[BITS_C] ? {1'b1, {(BITS_C-1){1'b0}}} : {1'b0, {(BITS_C-1){1'b1}}};
    end else begin
      c_d = sum[BITS_C-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
      c_q <= '0;
    end else if (en) begin
      a_q <= a_in;
      b_q <= b_in;
      c_q <= c_d;
    end
  end

  assign a_out = a_q;
  assign b_out = b_q;
  assign c     = c_q;

endmodule

// File: rtl/systolic_array.sv
// DIM x DIM output-stationary systolic matrix multiplier.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    control/data bundle (see systolic_array_if)
// A pass streams DIM A/B vectors in, then flushes zeros for 2*DIM-2 cycles so
// the last skewed operands reach PE(DIM-1,DIM-1), then pulses done.
module systolic_array
  import systolic_pkg::*;
#(
  parameter int unsigned BITS_AB = DefBitsAb,
  parameter int unsigned BITS_C  = DefBitsC,
  parameter int unsigned DIM     = DefDim,
  parameter bit          SAT     = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  systolic_array_if.slave   bus
);

  localparam int unsigned RowW      = row_bits(DIM);
  localparam int unsigned CntW      = $clog2(2 * DIM);
  localparam int unsigned FlushLast = 2 * DIM - 3;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              computing;
  logic [DIM-1:0]    row_wr;

  logic signed [BITS_AB-1:0] a_gated [DIM];
  logic signed [BITS_AB-1:0] b_gated [DIM];
  logic signed [BITS_AB-1:0] a_h     [DIM][DIM+1];  // a_h[i][j]: A entering PE(i,j)
  logic signed [BITS_AB-1:0] b_v     [DIM+1][DIM];  // b_v[i][j]: B entering PE(i,j)
  logic signed [BITS_C-1:0]  c_mat   [DIM][DIM];

  // Sequencer
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StCompute;
          cnt_d   = '0;
        end
      end
      StCompute: begin
        if (cnt_q == CntW'(DIM - 1)) begin
          state_d = StFlush;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StFlush: begin
        if (cnt_q == CntW'(FlushLast)) begin
          state_d = StDone;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else if (bus.en) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign computing = (state_q == StCompute);
  assign bus.busy  = (state_q != StIdle);
  assign bus.done  = (state_q == StDone);

  // Row writes are only honoured in idle, so they can share an edge with start.
  always_comb begin
    for (int i = 0; i < DIM; i++) begin
      row_wr[i] = bus.en && (state_q == StIdle) && bus.WrEn && (bus.Crow == RowW'(i));
    end
  end

  // Operands are zeroed outside the compute window so flush cycles add nothing.
  always_comb begin
    for (int i = 0; i < DIM; i++) begin
      a_gated[i] = computing ? bus.A[i] : '0;
      b_gated[i] = computing ? bus.B[i] : '0;
    end
  end

  // Input skew: row/column i is delayed by i cycles.
  for (genvar i = 0; i < DIM; i++) begin : g_skew
    if (i == 0) begin : g_direct
      assign a_h[0][0] = a_gated[0];
      assign b_v[0][0] = b_gated[0];
    end else begin : g_sr
      logic signed [BITS_AB-1:0] a_sr_q [i];
      logic signed [BITS_AB-1:0] b_sr_q [i];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int k = 0; k < i; k++) begin
            a_sr_q[k] <= '0;
            b_sr_q[k] <= '0;
          end
        end else if (bus.en) begin
          a_sr_q[0] <= a_gated[i];
          b_sr_q[0] <= b_gated[i];
          for (int k = 1; k < i; k++) begin
            a_sr_q[k] <= a_sr_q[k-1];
            b_sr_q[k] <= b_sr_q[k-1];
          end
        end
      end

      assign a_h[i][0] = a_sr_q[i-1];
      assign b_v[0][i] = b_sr_q[i-1];
    end
  end

  for (genvar i = 0; i < DIM; i++) begin : g_row
    for (genvar j = 0; j < DIM; j++) begin : g_col
      systolic_pe #(
        .BITS_AB (BITS_AB),
        .BITS_C  (BITS_C),
        .SAT     (SAT)
      ) u_pe (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (bus.en),
        .load  (row_wr[i]),
        .cin   (bus.Cin[j]),
        .a_in  (a_h[i][j]),
        .b_in  (b_v[i][j]),
        .a_out (a_h[i][j+1]),
        .b_out (b_v[i+1][j]),
        .c     (c_mat[i][j])
      );
    end
  end

  always_comb begin
    for (int j = 0; j < DIM; j++) begin
      bus.Cout[j] = c_mat[bus.Crow][j];
    end
  end

endmodule

// File: tb/tb_systolic_array.sv
// Bench for systolic_array at DIM=4, BITS_AB=8, BITS_C=16. A wrap-around and a
// saturating instance share the same stimulus.
module tb_systolic_array;

  localparam int D  = 4;
  localparam int BA = 8;
  localparam int BC = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  systolic_array_if #(.BITS_AB(BA), .BITS_C(BC), .DIM(D)) ifw ();
  systolic_array_if #(.BITS_AB(BA), .BITS_C(BC), .DIM(D)) ifs ();

  systolic_array #(.BITS_AB(BA), .BITS_C(BC), .DIM(D), .SAT(1'b0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifw)
  );

  systolic_array #(.BITS_AB(BA), .BITS_C(BC), .DIM(D), .SAT(1'b1)) dut_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifs)
  );

  assign ifs.en    = ifw.en;
  assign ifs.start = ifw.start;
  assign ifs.WrEn  = ifw.WrEn;
  assign ifs.Crow  = ifw.Crow;
  assign ifs.A     = ifw.A;
  assign ifs.B     = ifw.B;
  assign ifs.Cin   = ifw.Cin;

  typedef struct {
    string name;
    bit    preload;
    int    pre_row;
    int    pre_val;
    bit    stall;
    bit    poke;
    int    a [D][D];      // a[k][i]: vector k, row i
    int    b [D][D];      // b[k][j]: vector k, column j
    int    exp_w [D][D];
    int    exp_s [D][D];
    int    lat;
  } rec_t;

  typedef struct {
    string name;
    int    exp_w [D][D];
    int    exp_s [D][D];
    int    lat;
  } sb_t;

  localparam int NRec = 7;
  rec_t tbl [NRec];
  sb_t  sb_q [$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int wrap16(input int v);
    logic [15:0] t;
    t = v[15:0];
    return int'($signed(t));
  endfunction

  function automatic int sat16(input int v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // Reference matrix product on top of the (cleared or preloaded) accumulators.
  task automatic model_rec(inout rec_t r);
    for (int i = 0; i < D; i++) begin
      for (int j = 0; j < D; j++) begin
        int aw, as;
        aw = (r.preload && i == r.pre_row) ? r.pre_val : 0;
        as = aw;
        for (int k = 0; k < D; k++) begin
          aw = wrap16(aw + r.a[k][i] * r.b[k][j]);
          as = sat16(as + r.a[k][i] * r.b[k][j]);
        end
        r.exp_w[i][j] = aw;
        r.exp_s[i][j] = as;
      end
    end
  endtask

  task automatic write_row(input int row, input int val);
    ifw.en   = 1'b1;
    ifw.WrEn = 1'b1;
    ifw.Crow = 2'(row);
    for (int j = 0; j < D; j++) ifw.Cin[j] = 16'(val);
    tick();
    ifw.WrEn = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    for (int r = 0; r < D; r++) begin
      ifw.Crow = 2'(r);
      #1;
      for (int j = 0; j < D; j++) begin
        chk($sformatf("%s wrap c[%0d][%0d]", tag, r, j), int'($signed(ifw.Cout[j])), 0);
        chk($sformatf("%s sat c[%0d][%0d]", tag, r, j), int'($signed(ifs.Cout[j])), 0);
      end
    end
    ifw.Crow = '0;
  endtask

  task automatic run_record(input rec_t r);
    int  lat;
    bit  seen;
    sb_t e;
    for (int row = 0; row < D; row++) write_row(row, 0);
    if (r.preload) write_row(r.pre_row, r.pre_val);
    e.name  = r.name;
    e.exp_w = r.exp_w;
    e.exp_s = r.exp_s;
    e.lat   = r.lat;
    sb_q.push_back(e);

    ifw.en    = 1'b1;
    ifw.start = 1'b1;
    tick();
    ifw.start = 1'b0;
    lat = 1;
    for (int k = 0; k < D; k++) begin
      if (r.stall && k == 2) begin
        ifw.en = 1'b0;
        for (int i = 0; i < D; i++) begin
          ifw.A[i] = 8'h5a;
          ifw.B[i] = 8'ha5;
        end
        repeat (5) begin
          tick();
          lat++;
        end
        ifw.en = 1'b1;
      end
      for (int i = 0; i < D; i++) begin
        ifw.A[i] = 8'(r.a[k][i]);
        ifw.B[i] = 8'(r.b[k][i]);
      end
      if (r.poke && k == 1) begin
        ifw.start = 1'b1;
        ifw.WrEn  = 1'b1;
        ifw.Crow  = 2'd1;
        for (int j = 0; j < D; j++) ifw.Cin[j] = 16'h1234;
      end
      tick();
      lat++;
      ifw.start = 1'b0;
      ifw.WrEn  = 1'b0;
    end
    // Non-zero junk outside the compute window must not reach the PEs.
    for (int i = 0; i < D; i++) begin
      ifw.A[i] = 8'h33;
      ifw.B[i] = 8'h71;
    end
    seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      if (r.stall && n == 3) begin
        ifw.en = 1'b0;
        repeat (5) begin
          tick();
          lat++;
        end
        ifw.en = 1'b1;
      end
      tick();
      lat++;
      if (ifw.done === 1'b1) seen = 1'b1;
    end
    chk({r.name, " done seen"}, int'(seen), 1);
    e = sb_q.pop_front();
    if (seen) begin
      // Latency counts edges from the start edge (1) through the edge that samples done.
      chk({e.name, " latency"}, lat + 1, e.lat);
      chk({e.name, " busy at done"}, int'(ifw.busy), 1);
      chk({e.name, " sat done"}, int'(ifs.done), 1);
      for (int row = 0; row < D; row++) begin
        ifw.Crow = 2'(row);
        #1;
        for (int j = 0; j < D; j++) begin
          chk($sformatf("%s wrap c[%0d][%0d]", e.name, row, j),
              int'($signed(ifw.Cout[j])), e.exp_w[row][j]);
          chk($sformatf("%s sat c[%0d][%0d]", e.name, row, j),
              int'($signed(ifs.Cout[j])), e.exp_s[row][j]);
        end
      end
      ifw.Crow = '0;
      tick();
      chk({e.name, " done one cycle"}, int'(ifw.done), 0);
      chk({e.name, " idle after done"}, int'(ifw.busy), 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   bv [D][D];
    rec_t r;
    bv = '{'{5, -3, 127, -128}, '{0, 64, -77, 1}, '{-1, 2, -4, 8}, '{100, -100, 33, -45}};

    // Identity A: C equals the B matrix.
    r = '{name: "identity", preload: 1'b0, pre_row: 0, pre_val: 0, stall: 1'b0, poke: 1'b0,
          a: '{default: 0}, b: '{default: 0}, exp_w: '{default: 0}, exp_s: '{default: 0},
          lat: 12};
    for (int k = 0; k < D; k++) begin
      for (int i = 0; i < D; i++) begin
        r.a[k][i] = (i == k) ? 1 : 0;
        r.b[k][i] = bv[k][i];
        r.exp_w[k][i] = bv[k][i];
        r.exp_s[k][i] = bv[k][i];
      end
    end
    tbl[0] = r;
    r.name = "stall";  r.stall = 1'b1; r.lat = 22; tbl[1] = r;
    r.name = "poke";   r.stall = 1'b0; r.poke = 1'b1; r.lat = 12; tbl[2] = r;

    r.poke = 1'b0;
    r.name = "max127";
    r.a = '{default: 127};
    r.b = '{default: 127};
    r.exp_w = '{default: -1020};
    r.exp_s = '{default: 32767};
    tbl[3] = r;

    r.name = "negsat";
    r.b = '{default: -128};
    r.exp_w = '{default: 512};
    r.exp_s = '{default: -32768};
    tbl[4] = r;

    r.name = "preload";
    r.preload = 1'b1; r.pre_row = 2; r.pre_val = 100;
    r.a = '{default: 1};
    r.b = '{default: 1};
    for (int i = 0; i < D; i++) begin
      for (int j = 0; j < D; j++) begin
        r.exp_w[i][j] = (i == 2) ? 104 : 4;
        r.exp_s[i][j] = (i == 2) ? 104 : 4;
      end
    end
    tbl[5] = r;

    r.name = "random";
    r.preload = 1'b1; r.pre_row = 1; r.pre_val = -2000;
    for (int k = 0; k < D; k++) begin
      for (int i = 0; i < D; i++) begin
        r.a[k][i] = int'($urandom_range(255)) - 128;
        r.b[k][i] = int'($urandom_range(255)) - 128;
      end
    end
    model_rec(r);
    tbl[6] = r;

    ifw.en = 1'b0; ifw.start = 1'b0; ifw.WrEn = 1'b0; ifw.Crow = '0;
    ifw.A = '0; ifw.B = '0; ifw.Cin = '0;

    // Reset state
    #3;
    chk("reset busy", int'(ifw.busy), 0);
    chk("reset done", int'(ifw.done), 0);
    check_all_zero("reset");
    #20 rst_n = 1'b1;
    tick();

    // en=0 freezes the sequencer even with start high.
    ifw.start = 1'b1;
    tick();
    chk("en0 start ignored", int'(ifw.busy), 0);
    ifw.start = 1'b0;

    for (int t = 0; t < NRec; t++) run_record(tbl[t]);

    // Reset while flushing.
    for (int row = 0; row < D; row++) write_row(row, 0);
    ifw.en = 1'b1;
    ifw.start = 1'b1;
    tick();
    ifw.start = 1'b0;
    for (int k = 0; k < D; k++) begin
      ifw.A = '{default: 8'sd1};
      ifw.B = '{default: 8'sd1};
      tick();
    end
    repeat (3) tick();
    chk("flush busy", int'(ifw.busy), 1);
    ifw.Crow = '0;
    #1;
    chk("flush partial c00 nonzero", int'(ifw.Cout[0] != '0), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("midreset busy", int'(ifw.busy), 0);
    chk("midreset done", int'(ifw.done), 0);
    check_all_zero("midreset");
    tick();
    chk("held reset busy", int'(ifw.busy), 0);
    #2 rst_n = 1'b1;
    tick();
    run_record(tbl[0]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
